// File: rtl/mux_key_sel_pkg.sv
// Shared helpers for the key/value multiplexer.
// Only the pair-width function lives here; everything else is parameterised.
package mux_key_sel_pkg;

    function automatic int pair_len(input int key_len, input int data_len);
        return key_len + data_len;
    endfunction

endpackage

// File: rtl/mux_key_sel_if.sv
// Lookup bus between the table owner (master) and the priority search (slave).
interface mux_key_sel_if
    import mux_key_sel_pkg::*;
#(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
);
    localparam int PAIR_LEN = pair_len(KEY_LEN, DATA_LEN);

    logic [KEY_LEN-1:0]         key;
    logic [NR_KEY*PAIR_LEN-1:0] lut;
    logic [DATA_LEN-1:0]        out;
    logic                       hit;

    modport master (output key, output lut, input out, input hit);
    modport slave  (input key, input lut, output out, output hit);
endinterface

// File: rtl/mux_key_sel_core.sv
// Combinational priority search over a packed (key, data) table.
// The first-written pair (most-significant) wins when several keys match.
module mux_key_core
    import mux_key_sel_pkg::*;
#(
    parameter int          NR_KEY      = 2,
    parameter int          KEY_LEN     = 1,
    parameter int          DATA_LEN    = 1,
    parameter int unsigned DEFAULT_VAL = 0
) (
    mux_key_sel_if.slave bus
);
    localparam int PAIR_LEN = pair_len(KEY_LEN, DATA_LEN);
    localparam logic [DATA_LEN-1:0] DEF = DATA_LEN'(DEFAULT_VAL);

    if (NR_KEY < 1 || KEY_LEN < 1 || DATA_LEN < 1) begin : g_param_chk
        $error("mux_key_core: NR_KEY, KEY_LEN and DATA_LEN must all be >= 1");
    end

    logic [PAIR_LEN-1:0] pair;

    // Scan from the last pair up so the lowest index overwrites later matches.
    always_comb begin
        bus.out = DEF;
        bus.hit = 1'b0;
        pair    = '0;
        for (int j = NR_KEY - 1; j >= 0; j--) begin
            pair = bus.lut[(NR_KEY - j) * PAIR_LEN - 1 -: PAIR_LEN];
            if (pair[PAIR_LEN-1 -: KEY_LEN] == bus.key) begin
                bus.out = pair[DATA_LEN-1:0];
                bus.hit = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_key_sel.sv
// Key/value multiplexer: zero-latency select plus a registered copy.
// Port order is kept for existing positional instances (out, key, lut first).
module mux_key_sel
    import mux_key_sel_pkg::*;
#(
    parameter int          NR_KEY      = 2,
    parameter int          KEY_LEN     = 1,
    parameter int          DATA_LEN    = 1,
    parameter int unsigned DEFAULT_VAL = 0
) (
    output logic [DATA_LEN-1:0]                           out,
    input  logic [KEY_LEN-1:0]                            key,
    input  logic [NR_KEY*pair_len(KEY_LEN, DATA_LEN)-1:0] lut,
    input  logic                                          clk,
    input  logic                                          rst,
    output logic                                          hit,
    output logic [DATA_LEN-1:0]                           out_q,
    output logic                                          hit_q
);
    mux_key_sel_if #(
        .NR_KEY   (NR_KEY),
        .KEY_LEN  (KEY_LEN),
        .DATA_LEN (DATA_LEN)
    ) lk ();

    assign lk.key = key;
    assign lk.lut = lut;
    assign out    = lk.out;
    assign hit    = lk.hit;

    mux_key_core #(
        .NR_KEY      (NR_KEY),
        .KEY_LEN     (KEY_LEN),
        .DATA_LEN    (DATA_LEN),
        .DEFAULT_VAL (DEFAULT_VAL)
    ) u_core (
        .bus (lk.slave)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            hit_q <= 1'b0;
        end else begin
            out_q <= lk.out;
            hit_q <= lk.hit;
        end
    end
endmodule

// File: tb/tb_mux_key_sel.sv
// Directed bench for mux_key_sel across three parameter sets.
module tb_mux_key_sel;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    mux_key_sel_if #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(32)) ifa ();
    mux_key_sel_if #(.NR_KEY(2), .KEY_LEN(2), .DATA_LEN(8))  ifb ();
    mux_key_sel_if #(.NR_KEY(1), .KEY_LEN(4), .DATA_LEN(1))  ifc ();

    logic [31:0] outq_a;
    logic        hitq_a;
    logic [7:0]  outq_b;
    logic        hitq_b;
    logic [0:0]  outq_c;
    logic        hitq_c;

    mux_key_sel #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(32), .DEFAULT_VAL(0)) dut_a (
        .out(ifa.out), .key(ifa.key), .lut(ifa.lut), .clk(clk), .rst(rst),
        .hit(ifa.hit), .out_q(outq_a), .hit_q(hitq_a)
    );

    mux_key_sel #(.NR_KEY(2), .KEY_LEN(2), .DATA_LEN(8), .DEFAULT_VAL(32'hAA)) dut_b (
        .out(ifb.out), .key(ifb.key), .lut(ifb.lut), .clk(clk), .rst(rst),
        .hit(ifb.hit), .out_q(outq_b), .hit_q(hitq_b)
    );

    mux_key_sel #(.NR_KEY(1), .KEY_LEN(4), .DATA_LEN(1), .DEFAULT_VAL(0)) dut_c (
        .out(ifc.out), .key(ifc.key), .lut(ifc.lut), .clk(clk), .rst(rst),
        .hit(ifc.hit), .out_q(outq_c), .hit_q(hitq_c)
    );

    typedef struct {
        int          unit;
        logic [3:0]  key;
        logic [65:0] lut;
        logic [31:0] exp_out;
        logic        exp_hit;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    localparam logic [65:0] LUT_A = {1'b0, 32'h4, 1'b1, 32'h8000_0000};

    initial begin
        logic [31:0] act_out;
        logic        act_hit;

        ifa.key = '0; ifa.lut = LUT_A;
        ifb.key = '0; ifb.lut = '0;
        ifc.key = '0; ifc.lut = '0;

        vecs.push_back('{0, 4'd0, LUT_A, 32'h4, 1'b1});
        vecs.push_back('{0, 4'd1, LUT_A, 32'h8000_0000, 1'b1});
        vecs.push_back('{0, 4'd0, {1'b1, 32'h5, 1'b0, 32'h6}, 32'h6, 1'b1});
        vecs.push_back('{0, 4'd1, {1'b1, 32'h5, 1'b0, 32'h6}, 32'h5, 1'b1});
        vecs.push_back('{0, 4'd1, {1'b0, 32'h5, 1'b0, 32'h6}, 32'h0, 1'b0});
        vecs.push_back('{1, 4'd3, 66'({2'd0, 8'h11, 2'd1, 8'h22}), 32'hAA, 1'b0});
        vecs.push_back('{1, 4'd0, 66'({2'd0, 8'h11, 2'd1, 8'h22}), 32'h11, 1'b1});
        vecs.push_back('{1, 4'd1, 66'({2'd0, 8'h11, 2'd1, 8'h22}), 32'h22, 1'b1});
        vecs.push_back('{1, 4'd2, 66'({2'd0, 8'h11, 2'd1, 8'h22}), 32'hAA, 1'b0});
        vecs.push_back('{1, 4'd1, 66'({2'd1, 8'h33, 2'd1, 8'h44}), 32'h33, 1'b1});
        vecs.push_back('{1, 4'd0, 66'({2'd1, 8'h33, 2'd1, 8'h44}), 32'hAA, 1'b0});
        vecs.push_back('{1, 4'd2, 66'({2'd2, 8'h55, 2'd2, 8'h66}), 32'h55, 1'b1});
        vecs.push_back('{2, 4'hF, 66'({4'hF, 1'b1}), 32'h1, 1'b1});
        vecs.push_back('{2, 4'hE, 66'({4'hF, 1'b1}), 32'h0, 1'b0});
        vecs.push_back('{2, 4'h0, 66'({4'h0, 1'b0}), 32'h0, 1'b1});

        // Reset state of the registered outputs.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outq_a", outq_a, 32'h0);
        chk("rst_hitq_a", 32'(hitq_a), 32'h0);
        chk("rst_outq_b", 32'(outq_b), 32'h0);
        chk("rst_hitq_c", 32'(hitq_c), 32'h0);

        foreach (vecs[i]) begin
            act_out = '0;
            act_hit = 1'b0;
            case (vecs[i].unit)
                0: begin
                    ifa.key = vecs[i].key[0:0];
                    ifa.lut = vecs[i].lut;
                    #1;
                    act_out = ifa.out;
                    act_hit = ifa.hit;
                end
                1: begin
                    ifb.key = vecs[i].key[1:0];
                    ifb.lut = vecs[i].lut[19:0];
                    #1;
                    act_out = 32'(ifb.out);
                    act_hit = ifb.hit;
                end
                default: begin
                    ifc.key = vecs[i].key;
                    ifc.lut = vecs[i].lut[4:0];
                    #1;
                    act_out = 32'(ifc.out);
                    act_hit = ifc.hit;
                end
            endcase
            chk($sformatf("vec%0d_out", i), act_out, vecs[i].exp_out);
            chk($sformatf("vec%0d_hit", i), 32'(act_hit), 32'(vecs[i].exp_hit));
        end

        // Registered sweep 0,1,0 on the basic table.
        @(negedge clk);
        ifa.lut = LUT_A;
        ifa.key = 1'b0;
        ifb.lut = {2'd0, 8'h11, 2'd1, 8'h22};
        ifb.key = 2'd3;
        rst = 1'b0;
        @(negedge clk);
        chk("sweep0_outq", outq_a, 32'h4);
        chk("sweep0_hitq", 32'(hitq_a), 32'h1);
        chk("miss_outq_b", 32'(outq_b), 32'hAA);
        chk("miss_hitq_b", 32'(hitq_b), 32'h0);
        ifa.key = 1'b1;
        @(negedge clk);
        chk("sweep1_outq", outq_a, 32'h8000_0000);
        chk("sweep1_hitq", 32'(hitq_a), 32'h1);
        ifa.key = 1'b0;
        @(negedge clk);
        chk("sweep2_outq", outq_a, 32'h4);
        chk("sweep2_hitq", 32'(hitq_a), 32'h1);

        // One-edge reset mid-sweep; the combinational path must be untouched.
        ifa.key = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outq", outq_a, 32'h0);
        chk("midrst_hitq", 32'(hitq_a), 32'h0);
        chk("midrst_out", ifa.out, 32'h8000_0000);
        chk("midrst_hit", 32'(ifa.hit), 32'h1);
        rst = 1'b0;
        @(negedge clk);
        chk("resume_outq", outq_a, 32'h8000_0000);
        chk("resume_hitq", 32'(hitq_a), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mux_key_sel.md
# mux_key_sel

Parameterised key/value multiplexer: a packed lookup table of (key, data) pairs is searched for the entry whose key equals the `key` input, and that entry's data is driven on `out`. The result is combinational, so the PC adder and FSM next-state logic in the IFU can use it in the same cycle. A registered copy of the result and match flag is also provided for pipelined consumers. The block is leaf-level and instantiated throughout the core wherever a small decoded select is needed.

## Interface
Parameters:
- `NR_KEY`, 2: number of (key, data) pairs; must be ≥ 1.
- `KEY_LEN`, 1: width of each key and of `key`.
- `DATA_LEN`, 1: width of each data word and of `out`.
- `DEFAULT_VAL`, 0: value driven on `out` when no key matches; truncated or zero-extended to `DATA_LEN`.

Ports (listed clock/reset first):
- `clk` input 1: clock. Used only by the registered outputs.
- `rst` input 1: synchronous, active-high reset.
- `out` output `DATA_LEN`: combinational selected data.
- `key` input `KEY_LEN`: lookup key.
- `lut` input `NR_KEY*(KEY_LEN+DATA_LEN)`: packed table.
- `hit` output 1: combinational; 1 when at least one key matches.
- `out_q` output `DATA_LEN`: `out` registered on `clk`.
- `hit_q` output 1: `hit` registered on `clk`.

Declaration order is fixed as `out`, `key`, `lut`, `clk`, `rst`, `hit`, `out_q`, `hit_q`. Existing positional instances connect only the first three ports. When the trailing ports are left unconnected, the combinational path must still be fully functional.

## Operation
- Pair width: `PAIR_LEN = KEY_LEN + DATA_LEN`.
- Table layout: pairs are concatenated in the order written. Pair j (j = 0 is the most-significant, i.e. first-written) occupies `lut[(NR_KEY-j)*PAIR_LEN-1 -: PAIR_LEN]`. Within each pair, the key is the upper `KEY_LEN` bits and the data is the lower `DATA_LEN` bits.
- Match: pair j matches when its key equals `key` bit for bit. X and Z are not treated as wildcards.
- Priority: when several pairs match, the lowest j (first-written) wins.
- No match: `out = DEFAULT_VAL`, `hit = 0`.
- `out` and `hit` are purely combinational from `key` and `lut`. They contain no latches and are unaffected by `rst`.

## Timing
- `out` and `hit`: zero-cycle latency.
- `out_q` and `hit_q`: at each rising `clk`, `out_q <= out` and `hit_q <= hit`. Latency is 1 cycle.
- Reset: if `rst = 1` at a rising edge, then `out_q <= 0` and `hit_q <= 0`. Reset takes priority over capture, including when asserted mid-stream. Capture resumes on the first edge with `rst = 0`.
- There are no handshake or enable signals; the registers capture every cycle.

## Structure
- Sub-module `mux_key_core`: the combinational priority search, parameterised by `NR_KEY`, `KEY_LEN`, `DATA_LEN`, `DEFAULT_VAL`, with outputs `out` and `hit`. The top level adds only the two registers.
- The shared package holds only a constant function for pair width (`KEY_LEN + DATA_LEN`). No typedefs are needed because the block is fully parameterised.
- Elaboration check: fail when `NR_KEY < 1`, `KEY_LEN < 1` or `DATA_LEN < 1`.

## Test plan
1. Basic selection. Parameters `NR_KEY=2`, `KEY_LEN=1`, `DATA_LEN=32`; `lut = {1'b0, 32'h4, 1'b1, 32'h8000_0000}`.
   - `key=0` → `out=32'h4`, `hit=1`.
   - `key=1` → `out=32'h8000_0000`, `hit=1`.
   - Both results appear in the same cycle.
2. Miss. Parameters `NR_KEY=2`, `KEY_LEN=2`, `DATA_LEN=8`, `DEFAULT_VAL=8'hAA`; `lut = {2'd0, 8'h11, 2'd1, 8'h22}`; `key=2'd3` → `out=8'hAA`, `hit=0`.
3. Duplicate keys. `lut = {2'd1, 8'h33, 2'd1, 8'h44}`; `key=2'd1` → `out=8'h33` (first-written pair wins).
4. Registered path. With `rst=0`, sweep `key` through 0, 1, 0 on successive cycles using the test 1 table.
   - `out_q` follows `out` one cycle later: `4`, `8000_0000`, `4`.
   - `hit_q` stays 1.
5. Reset. Assert `rst` for one edge mid-sweep.
   - Next cycle: `out_q=0`, `hit_q=0`, while `out` remains correct.
   - The first edge after deassertion captures the current `out`.
6. Single-pair, wide-key case. Parameters `NR_KEY=1`, `KEY_LEN=4`, `DATA_LEN=1`; `lut = {4'hF, 1'b1}`.
   - `key=4'hF` → `out=1`, `hit=1`.
   - `key=4'hE` → `out=0`, `hit=0`.
